// File: rtl/updowncount_pkg.sv
// Shared definitions for the updowncount family: mode encodings, the Gray
// conversion helper and the elaboration-time parameter check macro.
// Optional feature macro used by the top level: UPDOWNCOUNT_GRAY_EN.

`ifndef UPDOWNCOUNT_PKG_MACROS
`define UPDOWNCOUNT_PKG_MACROS
// Raises an elaboration error inside a named generate block when cond is false.
`define UPDOWNCOUNT_CHECK(lbl, cond, msg) \
    if (!(cond)) begin : lbl \
        $error(msg); \
    end
`endif

package updowncount_pkg;

    // Boundary behaviour selected by the SAT input.
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Binary to reflected Gray code; callers slice the width they need.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/updowncount_core.sv
// Next-state logic for updowncount_mod: next count, next sticky flags and the
// terminal-count strobe. Purely combinational; the registers live in the top.

module updowncount_core
    import updowncount_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             sat,
    input  logic             clr_flg,
    input  logic             ovf,
    input  logic             unf,
    output logic [WIDTH-1:0] q_nxt,
    output logic             ovf_nxt,
    output logic             unf_nxt,
    output logic             tc
);

    // One extra bit so MODULUS itself (up to 2**WIDTH) is representable.
    localparam logic [WIDTH:0] MOD_EXT  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] LAST_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] d_ext;
    logic [WIDTH:0] q_inc;
    logic [WIDTH:0] q_dec;
    logic           at_last;
    logic           at_zero;

    assign q_ext   = {1'b0, q};
    assign d_ext   = {1'b0, d};
    assign q_inc   = q_ext + ONE_EXT;
    assign q_dec   = q_ext - ONE_EXT;
    assign at_last = (q_ext == LAST_EXT);
    assign at_zero = (q_ext == '0);

    // Next count and flags: load beats count beats hold; a boundary event sets
    // its flag even when a clear is requested on the same edge.
    always_comb begin
        q_nxt   = q;
        ovf_nxt = ovf & ~clr_flg;
        unf_nxt = unf & ~clr_flg;
        tc      = en & ~ld & ((up & at_last) | (~up & at_zero));
        if (ld) begin
            if (d_ext >= MOD_EXT) begin
                q_nxt = LAST_EXT[WIDTH-1:0];
            end else begin
                q_nxt = d;
            end
        end else if (en) begin
            if (up) begin
                if (at_last) begin
                    ovf_nxt = 1'b1;
                    if (sat == MODE_WRAP) begin
                        q_nxt = '0;
                    end
                end else begin
                    q_nxt = q_inc[WIDTH-1:0];
                end
            end else begin
                if (at_zero) begin
                    unf_nxt = 1'b1;
                    if (sat == MODE_WRAP) begin
                        q_nxt = LAST_EXT[WIDTH-1:0];
                    end
                end else begin
                    q_nxt = q_dec[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/updowncount_mod.sv
// Parametrised up/down counter with modulus, enable, load, wrap/saturate mode,
// terminal-count strobe and sticky overflow/underflow flags.
// Define UPDOWNCOUNT_GRAY_EN to add the registered Gray-coded output Q_GRAY.

module updowncount_mod
    import updowncount_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int RST_VAL = 0
) (
    input  logic             CK,
    input  logic             RES,
    input  logic             EN,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             SAT,
    input  logic             CLR_FLG,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OVF,
    output logic             UNF
`ifdef UPDOWNCOUNT_GRAY_EN
    ,
    output logic [WIDTH-1:0] Q_GRAY
`endif
);

    `UPDOWNCOUNT_CHECK(g_chk_width, WIDTH >= 2, "updowncount_mod: WIDTH must be >= 2")
    `UPDOWNCOUNT_CHECK(g_chk_mod, (MODULUS >= 2) && (MODULUS <= (1 << WIDTH)),
                       "updowncount_mod: MODULUS must lie in 2..2**WIDTH")
    `UPDOWNCOUNT_CHECK(g_chk_rst, (RST_VAL >= 0) && (RST_VAL < MODULUS),
                       "updowncount_mod: RST_VAL must be below MODULUS")

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] q_p0;
    logic             ovf_p0;
    logic             unf_p0;
    logic [WIDTH-1:0] q_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;
    logic             tc_c;

    updowncount_core #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_core (
        .q       (q_p0),
        .en      (EN),
        .up      (UP),
        .ld      (LD),
        .d       (D),
        .sat     (SAT),
        .clr_flg (CLR_FLG),
        .ovf     (ovf_p0),
        .unf     (unf_p0),
        .q_nxt   (q_nxt),
        .ovf_nxt (ovf_nxt),
        .unf_nxt (unf_nxt),
        .tc      (tc_c)
    );

    // Count and flag registers; reset overrides load and count.
    always_ff @(posedge CK) begin
        if (RES) begin
            q_p0   <= RST_Q;
            ovf_p0 <= 1'b0;
            unf_p0 <= 1'b0;
        end else begin
            q_p0   <= q_nxt;
            ovf_p0 <= ovf_nxt;
            unf_p0 <= unf_nxt;
        end
    end

`ifdef UPDOWNCOUNT_GRAY_EN
    localparam logic [31:0] RST_GRAY = bin2gray(32'(RST_VAL));

    logic [31:0]      gray_nxt;
    logic [WIDTH-1:0] q_gray_p0;

    assign gray_nxt = bin2gray(32'(q_nxt));

    // Gray register loads the code of the next count so it lines up with Q.
    always_ff @(posedge CK) begin
        if (RES) begin
            q_gray_p0 <= RST_GRAY[WIDTH-1:0];
        end else begin
            q_gray_p0 <= gray_nxt[WIDTH-1:0];
        end
    end

    assign Q_GRAY = q_gray_p0;
`endif

    assign Q   = q_p0;
    assign OVF = ovf_p0;
    assign UNF = unf_p0;
    assign TC  = tc_c;

endmodule

// File: tb/tb_updowncount_mod.sv
// Directed bench for updowncount_mod: a 16-state counter (dut_a) and a
// modulus-10 counter (dut_b) share the same stimulus.

module tb_updowncount_mod;

    logic       ck = 1'b0;
    logic       rs, en, up, ld, sat, clr;
    logic [3:0] d;
    logic [3:0] q_a, q_b;
    logic       tc_a, tc_b, ovf_a, ovf_b, unf_a, unf_b;
`ifdef UPDOWNCOUNT_GRAY_EN
    logic [3:0] qg_a, qg_b;
`endif

    int n_run  = 0;
    int n_fail = 0;

    always #50 ck = ~ck;

    updowncount_mod #(.WIDTH(4), .MODULUS(16), .RST_VAL(0)) dut_a (
        .CK(ck), .RES(rs), .EN(en), .UP(up), .LD(ld), .D(d), .SAT(sat),
        .CLR_FLG(clr), .Q(q_a), .TC(tc_a), .OVF(ovf_a), .UNF(unf_a)
`ifdef UPDOWNCOUNT_GRAY_EN
        , .Q_GRAY(qg_a)
`endif
    );

    updowncount_mod #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) dut_b (
        .CK(ck), .RES(rs), .EN(en), .UP(up), .LD(ld), .D(d), .SAT(sat),
        .CLR_FLG(clr), .Q(q_b), .TC(tc_b), .OVF(ovf_b), .UNF(unf_b)
`ifdef UPDOWNCOUNT_GRAY_EN
        , .Q_GRAY(qg_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
`ifdef UPDOWNCOUNT_GRAY_EN
        check("gray_a", 32'(qg_a), 32'(q_a ^ (q_a >> 1)));
        check("gray_b", 32'(qg_b), 32'(q_b ^ (q_b >> 1)));
`endif
    endtask

    initial begin
        rs = 1'b1; en = 1'b0; up = 1'b0; ld = 1'b0; d = 4'd0; sat = 1'b0; clr = 1'b0;
        step();
        check("rst_q_a", 32'(q_a), 32'd0);
        check("rst_q_b", 32'(q_b), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_unf", 32'(unf_a), 32'd0);
        check("rst_tc", 32'(tc_a), 32'd0);

        // Test 1: wrap-mode count up through the boundary.
        rs = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            #1;
            check("t1_tc", 32'(tc_a), 32'(((i - 1) % 16) == 15));
            step();
            check("t1_q", 32'(q_a), 32'(i % 16));
            check("t1_ovf", 32'(ovf_a), 32'(i >= 16));
        end

        // Test 2: count down from zero, then clear the flags.
        en = 1'b0; ld = 1'b1; d = 4'd0; clr = 1'b1;
        step();
        check("t2_ld_q", 32'(q_a), 32'd0);
        check("t2_clr_ovf", 32'(ovf_a), 32'd0);
        ld = 1'b0; clr = 1'b0; en = 1'b1; up = 1'b0;
        #1;
        check("t2_tc", 32'(tc_a), 32'd1);
        step();
        check("t2_q15", 32'(q_a), 32'd15);
        check("t2_unf", 32'(unf_a), 32'd1);
        #1;
        check("t2_tc_lo", 32'(tc_a), 32'd0);
        step();
        check("t2_q14", 32'(q_a), 32'd14);
        check("t2_unf_stk", 32'(unf_a), 32'd1);
        en = 1'b0; clr = 1'b1;
        step();
        check("t2_unf_clr", 32'(unf_a), 32'd0);
        check("t2_q_hold", 32'(q_a), 32'd14);
        clr = 1'b0; ld = 1'b1; d = 4'd0;
        step();
        ld = 1'b0; en = 1'b1; up = 1'b0; clr = 1'b1;
        step();
        check("t2_setwin_q", 32'(q_a), 32'd15);
        check("t2_setwin_unf", 32'(unf_a), 32'd1);

        // Test 3: saturate mode at both bounds.
        en = 1'b0; clr = 1'b1; sat = 1'b1; ld = 1'b1; d = 4'd13;
        step();
        check("t3_ld13", 32'(q_a), 32'd13);
        check("t3_ovf0", 32'(ovf_a), 32'd0);
        ld = 1'b0; clr = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #1;
            check("t3_tc", 32'(tc_a), 32'(i >= 3));
            step();
            check("t3_q", 32'(q_a), (i == 1) ? 32'd14 : 32'd15);
            check("t3_ovf", 32'(ovf_a), 32'(i >= 3));
        end
        en = 1'b0; ld = 1'b1; d = 4'd1; clr = 1'b1;
        step();
        check("t3_ld1", 32'(q_a), 32'd1);
        ld = 1'b0; clr = 1'b0; en = 1'b1; up = 1'b0;
        step();
        check("t3_dn_q0", 32'(q_a), 32'd0);
        check("t3_dn_unf0", 32'(unf_a), 32'd0);
        step();
        check("t3_dn_hold", 32'(q_a), 32'd0);
        check("t3_dn_unf1", 32'(unf_a), 32'd1);

        // Test 4: modulus 10, load clamp and wrap at 9.
        en = 1'b0; sat = 1'b0; ld = 1'b1; d = 4'd12; clr = 1'b1;
        step();
        check("t4_clamp_b", 32'(q_b), 32'd9);
        check("t4_noclamp_a", 32'(q_a), 32'd12);
        check("t4_ovf_b0", 32'(ovf_b), 32'd0);
        ld = 1'b0; clr = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        check("t4_tc_b", 32'(tc_b), 32'd1);
        step();
        check("t4_wrap_b", 32'(q_b), 32'd0);
        check("t4_ovf_b1", 32'(ovf_b), 32'd1);
        check("t4_q_a", 32'(q_a), 32'd13);

        // Test 5: load and enable together, with OVF already set.
        en = 1'b0; ld = 1'b1; d = 4'd15;
        step();
        ld = 1'b0; en = 1'b1; up = 1'b1;
        step();
        check("t5_pre_q", 32'(q_a), 32'd0);
        check("t5_pre_ovf", 32'(ovf_a), 32'd1);
        ld = 1'b1; en = 1'b1; up = 1'b0; d = 4'd5;
        #1;
        check("t5_tc", 32'(tc_a), 32'd0);
        step();
        check("t5_q", 32'(q_a), 32'd5);
        check("t5_ovf", 32'(ovf_a), 32'd1);
        check("t5_unf", 32'(unf_a), 32'd0);

        // Test 6: reset while counting up.
        ld = 1'b1; en = 1'b0; d = 4'd6;
        step();
        ld = 1'b0; en = 1'b1; up = 1'b1;
        step();
        check("t6_q7", 32'(q_a), 32'd7);
        rs = 1'b1;
        step();
        check("t6_rst_q", 32'(q_a), 32'd0);
        check("t6_rst_ovf", 32'(ovf_a), 32'd0);
        check("t6_rst_unf", 32'(unf_a), 32'd0);
        check("t6_rst_ovf_b", 32'(ovf_b), 32'd0);
        rs = 1'b0;
        step();
        check("t6_resume", 32'(q_a), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
